// File: rtl/mesi_pkg.sv
// Shared MESI encodings: line states, bus commands, one-hot snoop events and
// the requester FSM state type.
package mesi_pkg;

  // Line state encodings (shared with the listener half)
  localparam logic [2:0] ST_I = 3'b001;
  localparam logic [2:0] ST_S = 3'b010;
  localparam logic [2:0] ST_E = 3'b011;
  localparam logic [2:0] ST_M = 3'b100;

  // Bus command encodings
  localparam logic [2:0] CMD_NONE    = 3'b000;
  localparam logic [2:0] CMD_BUSRD   = 3'b001;
  localparam logic [2:0] CMD_BUSRDX  = 3'b010;
  localparam logic [2:0] CMD_BUSUPGR = 3'b011;
  localparam logic [2:0] CMD_WB      = 3'b100;

  // One-hot events {inv,wh,wm,rh,rm} decoded by remote listeners
  localparam logic [4:0] EV_NONE = 5'b00000;
  localparam logic [4:0] EV_INV  = 5'b10000;
  localparam logic [4:0] EV_WH   = 5'b01000;
  localparam logic [4:0] EV_WM   = 5'b00100;
  localparam logic [4:0] EV_RH   = 5'b00010;
  localparam logic [4:0] EV_RM   = 5'b00001;

  typedef enum logic [2:0] {
    StIdle,
    StWbReq,
    StWbXfer,
    StReq,
    StXfer,
    StAck
  } fsm_e;

endpackage

// File: rtl/emissor_mesi.sv
// Requester half of the per-line MESI controller: resolves CPU hits locally,
// arbitrates and issues bus commands on misses/upgrades, owns line state/tag.
module emissor_mesi import mesi_pkg::*; #(
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             cpu_req,
  input  logic             cpu_wr,
  input  logic [TAG_W-1:0] cpu_tag,
  output logic             cpu_ack,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [2:0]       bus_cmd,
  output logic [TAG_W-1:0] bus_tag,
  output logic [4:0]       bus_event,
  input  logic             bus_done,
  input  logic             bus_shared,
  input  logic             bus_abort,
  input  logic             snoop_we,
  input  logic [2:0]       snoop_state,
  output logic             controle,
  output logic [2:0]       state,
  output logic             err
);

  localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);

  fsm_e              r_fsm;
  logic [2:0]        r_state;
  logic [TAG_W-1:0]  r_tag;
  logic [RetryW-1:0] r_retry;
  logic [2:0]        r_pend_cmd;
  logic [4:0]        r_pend_ev;
  logic              r_cpu_ack;
  logic              r_bus_req;
  logic [2:0]        r_bus_cmd;
  logic [TAG_W-1:0]  r_bus_tag;
  logic [4:0]        r_bus_event;
  logic              r_controle;
  logic              r_err;

  logic              w_hit;
  logic              w_wb;
  logic [2:0]        w_miss_cmd;
  logic [4:0]        w_miss_ev;

  // Hit/miss decision and the command a miss would issue
  always_comb begin
    w_hit      = (r_state != ST_I) && (cpu_tag == r_tag);
    w_wb       = (r_state == ST_M) && (cpu_tag != r_tag);
    w_miss_cmd = cpu_wr ? CMD_BUSRDX : CMD_BUSRD;
    w_miss_ev  = cpu_wr ? EV_WM : EV_RM;
  end

  // Requester FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_fsm       <= StIdle;
      r_state     <= ST_I;
      r_tag       <= '0;
      r_retry     <= '0;
      r_pend_cmd  <= CMD_NONE;
      r_pend_ev   <= EV_NONE;
      r_cpu_ack   <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_cmd   <= CMD_NONE;
      r_bus_tag   <= '0;
      r_bus_event <= EV_NONE;
      r_controle  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      unique case (r_fsm)
        StIdle: begin
          // Snoop writes win; the CPU request is re-evaluated next cycle
          if (snoop_we) begin
            r_state <= snoop_state;
          end else if (cpu_req) begin
            r_controle <= 1'b1;
            if (w_hit && !cpu_wr) begin
              r_fsm     <= StAck;
              r_cpu_ack <= 1'b1;
            end else if (w_hit && (r_state == ST_E || r_state == ST_M)) begin
              r_state   <= ST_M;
              r_fsm     <= StAck;
              r_cpu_ack <= 1'b1;
            end else if (w_hit) begin
              r_pend_cmd <= CMD_BUSUPGR;
              r_pend_ev  <= EV_INV;
              r_bus_req  <= 1'b1;
              r_fsm      <= StReq;
            end else begin
              r_pend_cmd <= w_miss_cmd;
              r_pend_ev  <= w_miss_ev;
              r_bus_req  <= 1'b1;
              r_fsm      <= w_wb ? StWbReq : StReq;
            end
          end
        end
        StWbReq: begin
          if (bus_gnt) begin
            r_bus_req <= 1'b0;
            r_bus_cmd <= CMD_WB;
            r_bus_tag <= r_tag;
            r_fsm     <= StWbXfer;
          end
        end
        StWbXfer: begin
          if (bus_done) begin
            r_state   <= ST_I;
            r_bus_cmd <= CMD_NONE;
            r_bus_req <= 1'b1;
            r_fsm     <= StReq;
          end
        end
        StReq: begin
          // Only a grant to a request we are actually raising counts
          r_bus_req <= 1'b1;
          if (bus_gnt && r_bus_req) begin
            r_bus_cmd   <= r_pend_cmd;
            r_bus_tag   <= cpu_tag;
            r_bus_event <= r_pend_ev;
            r_fsm       <= StXfer;
          end
        end
        StXfer: begin
          r_bus_event <= EV_NONE;
          if (bus_abort) begin
            r_bus_req <= 1'b0;
            r_bus_cmd <= CMD_NONE;
            if (r_retry >= RetryW'(MAX_RETRY)) begin
              r_err     <= 1'b1;
              r_state   <= ST_I;
              r_cpu_ack <= 1'b1;
              r_fsm     <= StAck;
            end else begin
              r_retry <= r_retry + 1'b1;
              r_fsm   <= StReq;
            end
          end else if (bus_done) begin
            if (r_pend_cmd == CMD_BUSRD) begin
              r_state <= bus_shared ? ST_S : ST_E;
            end else begin
              r_state <= ST_M;
            end
            r_tag     <= cpu_tag;
            r_bus_req <= 1'b0;
            r_bus_cmd <= CMD_NONE;
            r_cpu_ack <= 1'b1;
            r_fsm     <= StAck;
          end
        end
        StAck: begin
          r_cpu_ack  <= 1'b0;
          r_retry    <= '0;
          r_controle <= 1'b0;
          r_fsm      <= StIdle;
        end
        default: r_fsm <= StIdle;
      endcase
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign bus_req   = r_bus_req;
  assign bus_cmd   = r_bus_cmd;
  assign bus_tag   = r_bus_tag;
  assign bus_event = r_bus_event;
  assign controle  = r_controle;
  assign state     = r_state;
  assign err       = r_err;

endmodule

// File: tb/tb_emissor_mesi.sv
// Directed bench for emissor_mesi; all expected values are hand-derived.
module tb_emissor_mesi;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       cpu_req = 1'b0;
  logic       cpu_wr = 1'b0;
  logic [7:0] cpu_tag = '0;
  logic       cpu_ack;
  logic       bus_req;
  logic       bus_gnt = 1'b0;
  logic [2:0] bus_cmd;
  logic [7:0] bus_tag;
  logic [4:0] bus_event;
  logic       bus_done = 1'b0;
  logic       bus_shared = 1'b0;
  logic       bus_abort = 1'b0;
  logic       snoop_we = 1'b0;
  logic [2:0] snoop_state = 3'b001;
  logic       controle;
  logic [2:0] state;
  logic       err;

  int n_cmp = 0;
  int n_fail = 0;

  emissor_mesi #(.TAG_W(8), .MAX_RETRY(3)) dut (
    .CLK(CLK), .CLR(CLR),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_tag(cpu_tag), .cpu_ack(cpu_ack),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd), .bus_tag(bus_tag),
    .bus_event(bus_event), .bus_done(bus_done), .bus_shared(bus_shared),
    .bus_abort(bus_abort), .snoop_we(snoop_we), .snoop_state(snoop_state),
    .controle(controle), .state(state), .err(err)
  );

  always #5 CLK = ~CLK;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    step(); step();
    CLR = 1'b0;
    chk("rst_state", 32'(state), 32'h1);
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_cmd", 32'(bus_cmd), 32'h0);
    chk("rst_event", 32'(bus_event), 32'h0);
    chk("rst_tag", 32'(bus_tag), 32'h0);
    chk("rst_ctl", 32'(controle), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_ack", 32'(cpu_ack), 32'h0);

    // 1: read miss 0x12, exclusive fill
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_tag = 8'h12;
    step();
    chk("t1_req", 32'(bus_req), 32'h1);
    chk("t1_ctl", 32'(controle), 32'h1);
    chk("t1_cmd_pre", 32'(bus_cmd), 32'h0);
    bus_gnt = 1'b1;
    step();
    chk("t1_cmd", 32'(bus_cmd), 32'h1);
    chk("t1_event", 32'(bus_event), 32'h01);
    chk("t1_btag", 32'(bus_tag), 32'h12);
    bus_gnt = 1'b0;
    step();
    chk("t1_event_pulse", 32'(bus_event), 32'h0);
    chk("t1_cmd_hold", 32'(bus_cmd), 32'h1);
    chk("t1_req_hold", 32'(bus_req), 32'h1);
    bus_done = 1'b1;
    step();
    chk("t1_state", 32'(state), 32'h3);
    chk("t1_ack", 32'(cpu_ack), 32'h1);
    chk("t1_req_drop", 32'(bus_req), 32'h0);
    bus_done = 1'b0; cpu_req = 1'b0;
    step();
    chk("t1_ack_once", 32'(cpu_ack), 32'h0);
    chk("t1_ctl_idle", 32'(controle), 32'h0);

    // 2: write hit in E -> M silently
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_tag = 8'h12;
    step();
    chk("t2_state", 32'(state), 32'h4);
    chk("t2_ack", 32'(cpu_ack), 32'h1);
    chk("t2_no_bus", 32'(bus_req), 32'h0);
    cpu_req = 1'b0;
    step();
    chk("t2_ack_once", 32'(cpu_ack), 32'h0);
    chk("t2_no_bus2", 32'(bus_req), 32'h0);

    // 3: listener moves line to S, then write hit -> BusUpgr
    snoop_we = 1'b1; snoop_state = 3'b010;
    step();
    snoop_we = 1'b0;
    chk("t3_snoop", 32'(state), 32'h2);
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_tag = 8'h12;
    step();
    chk("t3_req", 32'(bus_req), 32'h1);
    bus_gnt = 1'b1;
    step();
    chk("t3_cmd", 32'(bus_cmd), 32'h3);
    chk("t3_event", 32'(bus_event), 32'h10);
    bus_gnt = 1'b0;
    step();
    chk("t3_event_pulse", 32'(bus_event), 32'h0);
    bus_done = 1'b1;
    step();
    chk("t3_state", 32'(state), 32'h4);
    chk("t3_ack", 32'(cpu_ack), 32'h1);
    bus_done = 1'b0; cpu_req = 1'b0;
    step();

    // 4: M line 0x12, read 0x34 -> WriteBack 0x12 then BusRd 0x34 shared
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_tag = 8'h34;
    step();
    chk("t4_wb_req", 32'(bus_req), 32'h1);
    chk("t4_wb_cmd_pre", 32'(bus_cmd), 32'h0);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk("t4_wb_cmd", 32'(bus_cmd), 32'h4);
    chk("t4_wb_tag", 32'(bus_tag), 32'h12);
    chk("t4_wb_event", 32'(bus_event), 32'h0);
    bus_done = 1'b1;
    step();
    bus_done = 1'b0;
    chk("t4_wb_inv", 32'(state), 32'h1);
    chk("t4_wb_cmd_drop", 32'(bus_cmd), 32'h0);
    chk("t4_rd_req", 32'(bus_req), 32'h1);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk("t4_rd_cmd", 32'(bus_cmd), 32'h1);
    chk("t4_rd_tag", 32'(bus_tag), 32'h34);
    chk("t4_rd_event", 32'(bus_event), 32'h01);
    bus_done = 1'b1; bus_shared = 1'b1;
    step();
    chk("t4_state", 32'(state), 32'h2);
    chk("t4_ack", 32'(cpu_ack), 32'h1);
    bus_done = 1'b0; bus_shared = 1'b0; cpu_req = 1'b0;
    step();
    // Read 0x34 must now hit
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_tag = 8'h34;
    step();
    chk("t4_hit_ack", 32'(cpu_ack), 32'h1);
    chk("t4_hit_nobus", 32'(bus_req), 32'h0);
    cpu_req = 1'b0;
    step();

    // 5: write miss 0x56 aborted four times -> err, line invalid
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_tag = 8'h56;
    step();
    for (int k = 1; k <= 4; k++) begin
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0;
      chk("t5_cmd", 32'(bus_cmd), 32'h2);
      chk("t5_event", 32'(bus_event), 32'h04);
      bus_abort = 1'b1;
      step();
      bus_abort = 1'b0;
      if (k < 4) begin
        chk("t5_req_drop", 32'(bus_req), 32'h0);
        chk("t5_no_err", 32'(err), 32'h0);
        chk("t5_no_ack", 32'(cpu_ack), 32'h0);
        step();
        chk("t5_rearb", 32'(bus_req), 32'h1);
      end else begin
        chk("t5_err", 32'(err), 32'h1);
        chk("t5_state", 32'(state), 32'h1);
        chk("t5_ack", 32'(cpu_ack), 32'h1);
      end
    end
    cpu_req = 1'b0;
    step();
    chk("t5_err_sticky", 32'(err), 32'h1);
    chk("t5_ack_once", 32'(cpu_ack), 32'h0);

    // 6: snoop invalidate races a read hit; request becomes a miss
    snoop_we = 1'b1; snoop_state = 3'b011;
    step();
    chk("t6_pre_e", 32'(state), 32'h3);
    snoop_state = 3'b001;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_tag = 8'h34;
    step();
    snoop_we = 1'b0;
    chk("t6_inv", 32'(state), 32'h1);
    chk("t6_no_ack", 32'(cpu_ack), 32'h0);
    chk("t6_ctl", 32'(controle), 32'h0);
    step();
    chk("t6_req", 32'(bus_req), 32'h1);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk("t6_cmd", 32'(bus_cmd), 32'h1);
    chk("t6_event", 32'(bus_event), 32'h01);
    bus_done = 1'b1;
    step();
    bus_done = 1'b0;
    chk("t6_state", 32'(state), 32'h3);
    chk("t6_ack", 32'(cpu_ack), 32'h1);
    cpu_req = 1'b0;
    step();

    // CLR mid-transaction abandons the request and clears err
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_tag = 8'h77;
    step();
    chk("clr_pre_req", 32'(bus_req), 32'h1);
    CLR = 1'b1;
    step();
    CLR = 1'b0; cpu_req = 1'b0;
    chk("clr_req", 32'(bus_req), 32'h0);
    chk("clr_ctl", 32'(controle), 32'h0);
    chk("clr_err", 32'(err), 32'h0);
    chk("clr_state", 32'(state), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
